// File: rtl/hyperram_byte_arb_pkg.sv
// Shared HyperRAM front-end definitions: FSM encoding, byte-lane constants and
// the byte-address to word-bus mapping helpers (also used by the DMA engine).
package hyperram_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Lane index within the 16-bit word; the even byte lives in the upper half.
   localparam logic LANE_EVEN = 1'b1;
   localparam logic LANE_ODD  = 1'b0;

   // Controller word address for a zero-extended word index.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [31:0] word_idx);
      return base + word_idx;
   endfunction

   // Lane selected by the byte address LSB.
   function automatic logic lane_of(input logic addr_lsb);
      return addr_lsb ? LANE_ODD : LANE_EVEN;
   endfunction

   // Byte held in the given lane of a word.
   function automatic logic [7:0] lane_byte(input logic [15:0] word,
                                            input logic        lane);
      return (lane == LANE_EVEN) ? word[15:8] : word[7:0];
   endfunction

   // Word with one lane replaced by a new byte, other lane kept.
   function automatic logic [15:0] merge_lane(input logic [15:0] word,
                                              input logic        lane,
                                              input logic [7:0]  data);
      return (lane == LANE_EVEN) ? {data, word[7:0]} : {word[15:8], data};
   endfunction

   // Byte-lane write strobe, 1 = lane written.
   function automatic logic [1:0] lane_strobe(input logic lane);
      return (lane == LANE_EVEN) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/hyperram_byte_arb_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational and only offered while
// enabled; the last granted port is remembered on every accept so that the
// other port wins the next contested cycle. Port 0 wins first after reset.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic [1:0] i_valid,
   output logic [1:0] o_grant
);

   logic       r_last;
   logic [1:0] w_grant;

   // One-hot grant: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      w_grant = 2'b00;
      if (i_en) begin
         case (i_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end else begin
         w_grant = 2'b00;
      end
   end

   // Remember which port was accepted; a grant is always an accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (|w_grant) begin
         r_last <= w_grant[1];
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/hyperram_byte_arb.sv
// HyperRAM upstream front end: arbitrates two byte clients onto the 16-bit
// req/ack toggle word bus, with posted lane-strobed writes and a one-word
// read buffer that answers repeat reads of the same word without a RAM access.
module hyperram_byte_arb
   import hyperram_pkg::*;
#(
   parameter int          ADDR_W    = 24,
   parameter logic [31:0] WORD_BASE = 32'h0,
   parameter bit          RDBUF_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [7:0]        p0_wdata,
   output logic [7:0]        p0_rdata,
   output logic              p0_rvalid,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [7:0]        p1_wdata,
   output logic [7:0]        p1_rdata,
   output logic              p1_rvalid,
   output logic              hr_as,
   output logic              hr_we,
   output logic              hr_linear,
   output logic [31:0]       hr_a,
   output logic [15:0]       hr_d,
   output logic [1:0]        hr_ds,
   input  logic [15:0]       hr_q,
   output logic              hr_req,
   input  logic              hr_ack
);

   localparam int TAG_W = ADDR_W - 1;

   state_t            r_state, w_state_nxt;
   logic [1:0]        w_gnt;
   logic              w_sel, w_acc, w_we, w_lane, w_rd_hit, w_issue, w_ack_match, w_done_rd;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_wdata;
   logic [TAG_W-1:0]  w_tag;
   logic              r_req, r_hr_we, r_port, r_lane, r_is_rd;
   logic [31:0]       r_hr_a;
   logic [15:0]       r_hr_d;
   logic [1:0]        r_hr_ds;
   logic [TAG_W-1:0]  r_pend_tag;
   logic              r_buf_valid;
   logic [TAG_W-1:0]  r_buf_tag;
   logic [15:0]       r_buf_data;
   logic              w_rsp_fire, w_rsp_port;
   logic [7:0]        w_rsp_byte;
   logic [7:0]        r_p0_rdata, r_p1_rdata;
   logic              r_p0_rvalid, r_p1_rvalid;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_en    (r_state == ST_IDLE),
      .i_valid ({p1_valid, p0_valid}),
      .o_grant (w_gnt)
   );

   // Select the winning client's request and classify it as hit or RAM access.
   always_comb begin
      w_sel = w_gnt[1];
      w_acc = |w_gnt;
      if (w_sel) begin
         w_we    = p1_we;
         w_addr  = p1_addr;
         w_wdata = p1_wdata;
      end else begin
         w_we    = p0_we;
         w_addr  = p0_addr;
         w_wdata = p0_wdata;
      end
      w_tag       = w_addr[ADDR_W-1:1];
      w_lane      = lane_of(w_addr[0]);
      w_rd_hit    = RDBUF_EN && r_buf_valid && (r_buf_tag == w_tag) && !w_we;
      w_issue     = w_acc && !w_rd_hit;
      w_ack_match = (hr_ack == r_req);
      w_done_rd   = (r_state == ST_WAIT) && w_ack_match && r_is_rd;
   end

   // Next state: a RAM access parks in WAIT until the ack toggle catches up.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) w_state_nxt = ST_WAIT;
            else         w_state_nxt = ST_IDLE;
         end
         ST_WAIT: begin
            if (w_ack_match) w_state_nxt = ST_IDLE;
            else             w_state_nxt = ST_WAIT;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Launch a RAM access: register the word-bus request and toggle req.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req      <= 1'b0;
         r_hr_we    <= 1'b0;
         r_hr_a     <= 32'h0;
         r_hr_d     <= 16'h0;
         r_hr_ds    <= 2'b00;
         r_port     <= 1'b0;
         r_lane     <= 1'b0;
         r_is_rd    <= 1'b0;
         r_pend_tag <= '0;
      end else if (w_issue) begin
         r_req      <= ~r_req;
         r_hr_we    <= w_we;
         r_hr_a     <= word_addr(WORD_BASE, 32'(w_tag));
         r_hr_d     <= w_we ? merge_lane(16'h0, w_lane, w_wdata) : 16'h0;
         r_hr_ds    <= w_we ? lane_strobe(w_lane) : 2'b00;
         r_port     <= w_sel;
         r_lane     <= w_lane;
         r_is_rd    <= !w_we;
         r_pend_tag <= w_tag;
      end
   end

   // Read buffer: patched by writes to the buffered word, refilled by read misses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_buf_tag   <= '0;
         r_buf_data  <= 16'h0;
      end else if (w_acc && w_we && r_buf_valid && (r_buf_tag == w_tag)) begin
         r_buf_data <= merge_lane(r_buf_data, w_lane, w_wdata);
      end else if (w_done_rd && RDBUF_EN) begin
         r_buf_valid <= 1'b1;
         r_buf_tag   <= r_pend_tag;
         r_buf_data  <= hr_q;
      end
   end

   // Pick the read response: buffer hit at accept, or RAM data at ack.
   always_comb begin
      w_rsp_fire = 1'b0;
      w_rsp_port = 1'b0;
      w_rsp_byte = 8'h00;
      if (w_acc && w_rd_hit) begin
         w_rsp_fire = 1'b1;
         w_rsp_port = w_sel;
         w_rsp_byte = lane_byte(r_buf_data, w_lane);
      end else if (w_done_rd) begin
         w_rsp_fire = 1'b1;
         w_rsp_port = r_port;
         w_rsp_byte = lane_byte(hr_q, r_lane);
      end else begin
         w_rsp_fire = 1'b0;
      end
   end

   // Deliver read data only to the requesting port; rdata holds until its next read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_p0_rdata  <= 8'h00;
         r_p1_rdata  <= 8'h00;
         r_p0_rvalid <= 1'b0;
         r_p1_rvalid <= 1'b0;
      end else begin
         r_p0_rvalid <= w_rsp_fire && !w_rsp_port;
         r_p1_rvalid <= w_rsp_fire &&  w_rsp_port;
         if (w_rsp_fire && !w_rsp_port) r_p0_rdata <= w_rsp_byte;
         if (w_rsp_fire &&  w_rsp_port) r_p1_rdata <= w_rsp_byte;
      end
   end

   assign p0_ready  = w_gnt[0];
   assign p1_ready  = w_gnt[1];
   assign p0_rdata  = r_p0_rdata;
   assign p1_rdata  = r_p1_rdata;
   assign p0_rvalid = r_p0_rvalid;
   assign p1_rvalid = r_p1_rvalid;
   assign hr_as     = 1'b0;
   assign hr_linear = 1'b0;
   assign hr_we     = r_hr_we;
   assign hr_a      = r_hr_a;
   assign hr_d      = r_hr_d;
   assign hr_ds     = r_hr_ds;
   assign hr_req    = r_req;

endmodule

// File: tb/tb_hyperram_byte_arb.sv
// Bench for hyperram_byte_arb: directed scenarios plus a randomized phase,
// checked against a byte-memory / one-word-buffer reference model and a
// word RAM controller model with programmable ack latency.
module tb_hyperram_byte_arb;

   localparam logic [31:0] TB_BASE = 32'h100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p0_valid = 1'b0, p0_we = 1'b0, p1_valid = 1'b0, p1_we = 1'b0;
   logic [23:0] p0_addr = 24'h0, p1_addr = 24'h0;
   logic [7:0]  p0_wdata = 8'h0, p1_wdata = 8'h0;
   logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid;
   logic [7:0]  p0_rdata, p1_rdata;
   logic        hr_as, hr_we, hr_linear, hr_req;
   logic        hr_ack = 1'b0;
   logic [31:0] hr_a;
   logic [15:0] hr_d;
   logic [1:0]  hr_ds;
   logic [15:0] hr_q = 16'h0;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int n_tog = 0;
   int n_rv [2] = '{0, 0};
   int exp_rd [2] = '{0, 0};
   int ack_delay = 0;

   hyperram_byte_arb #(.ADDR_W(24), .WORD_BASE(TB_BASE), .RDBUF_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
      .hr_as(hr_as), .hr_we(hr_we), .hr_linear(hr_linear), .hr_a(hr_a), .hr_d(hr_d),
      .hr_ds(hr_ds), .hr_q(hr_q), .hr_req(hr_req), .hr_ack(hr_ack)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: byte memory + one-word buffer ----------
   logic [7:0] bmem [int];
   bit         mbuf_v = 1'b0;
   int         mbuf_w = 0;

   function automatic logic [15:0] dflt_word(input logic [31:0] a);
      return a[15:0] ^ 16'h5A3C;
   endfunction

   function automatic logic [7:0] model_byte(input logic [23:0] addr);
      logic [15:0] w;
      if (bmem.exists(int'(addr))) return bmem[int'(addr)];
      w = dflt_word(TB_BASE + 32'(addr >> 1));
      return addr[0] ? w[7:0] : w[15:8];
   endfunction

   // ---------------- controller model: word RAM with toggle handshake --------
   logic [15:0] ram [logic [31:0]];
   bit          c_pend = 1'b0;
   int          c_cnt = 0;
   logic [15:0] c_word;

   always @(posedge clk) begin
      if (reset) begin
         hr_ack <= 1'b0;
         c_pend = 1'b0;
         c_cnt  = 0;
      end else if (!c_pend) begin
         if (hr_req != hr_ack) begin
            c_pend = 1'b1;
            c_cnt  = ack_delay;
         end
      end else if (c_cnt > 0) begin
         c_cnt--;
      end else begin
         c_word = ram.exists(hr_a) ? ram[hr_a] : dflt_word(hr_a);
         if (hr_we) begin
            if (hr_ds[1]) c_word[15:8] = hr_d[15:8];
            if (hr_ds[0]) c_word[7:0]  = hr_d[7:0];
            ram[hr_a] = c_word;
         end else begin
            hr_q <= c_word;
         end
         hr_ack <= hr_req;
         c_pend = 1'b0;
      end
   end

   // Count req toggles issued outside reset and read pulses per port.
   always @(hr_req) if (!reset) n_tog++;
   always @(negedge clk) begin
      if (p0_rvalid) n_rv[0]++;
      if (p1_rvalid) n_rv[1]++;
   end

   // ---------------- helpers -------------------------------------------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int port, input logic v, input logic we,
                        input logic [23:0] a, input logic [7:0] d);
      if (port == 0) begin
         p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d;
      end else begin
         p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d;
      end
   endtask

   function automatic logic rdy(input int port);
      return (port == 0) ? p0_ready : p1_ready;
   endfunction
   function automatic logic rv(input int port);
      return (port == 0) ? p0_rvalid : p1_rvalid;
   endfunction
   function automatic logic [7:0] rd(input int port);
      return (port == 0) ? p0_rdata : p1_rdata;
   endfunction

   // One complete client access with model update and response checks.
   task automatic access(input int port, input logic we, input logic [23:0] addr,
                         input logic [7:0] wd);
      int b, tog0;
      logic [7:0] oth0, expd;
      logic hit;
      @(negedge clk);
      drive(port, 1'b1, we, addr, wd);
      #1;
      b = 0;
      while (!rdy(port) && b < 200) begin
         @(negedge clk); #1; b++;
      end
      check("accept_in_time", 64'(b < 200), 64'd1);
      if (b >= 200) begin
         drive(port, 1'b0, 1'b0, 24'h0, 8'h0);
         return;
      end
      tog0 = n_tog;
      oth0 = rd(1 - port);
      hit  = !we && mbuf_v && (mbuf_w == int'(addr >> 1));
      if (we) bmem[int'(addr)] = wd;
      else begin
         if (!hit) begin mbuf_v = 1'b1; mbuf_w = int'(addr >> 1); end
         exp_rd[port]++;
      end
      expd = model_byte(addr);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 24'h0, 8'h0);
      @(negedge clk);
      check("req_toggles", 64'(n_tog - tog0), hit ? 64'd0 : 64'd1);
      if (!hit) begin
         check("hr_a", hr_a, TB_BASE + 32'(addr >> 1));
         check("hr_we", hr_we, we);
      end
      if (we) begin
         check("hr_ds", hr_ds, addr[0] ? 2'b01 : 2'b10);
         check("hr_d_lane", addr[0] ? hr_d[7:0] : hr_d[15:8], wd);
      end else begin
         if (!hit) begin
            b = 0;
            while (!rv(port) && b < 200) begin @(negedge clk); b++; end
         end
         check(hit ? "hit_rvalid_at_accept_plus1" : "miss_rvalid", rv(port), 1'b1);
         check("rdata", rd(port), expd);
         check("other_rdata_held", rd(1 - port), oth0);
      end
   endtask

   // ---------------- directed + random sequence ------------------------------
   logic [23:0] a0 [2] = '{24'h000010, 24'h000015};
   logic [23:0] a1 [2] = '{24'h000020, 24'h000027};
   logic [7:0]  e0 [2], e1 [2];
   int          gr [$];
   logic [7:0]  q0 [$], q1 [$];
   int          i0, i1, b, w, tog0, rv0;
   logic [31:0] cap_a;
   logic [15:0] cap_d;
   logic [1:0]  cap_ds;
   logic        cap_we;

   initial begin
      bmem[2] = 8'h12; bmem[3] = 8'h34;
      ram[TB_BASE + 32'h1] = 16'h1234;

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_hr_req", hr_req, 1'b0);
      check("rst_hr_we", hr_we, 1'b0);
      check("rst_hr_a", hr_a, 32'h0);
      check("rst_hr_d", hr_d, 16'h0);
      check("rst_hr_ds", hr_ds, 2'b00);
      check("rst_ready", {p0_ready, p1_ready}, 2'b00);
      check("rst_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
      check("rst_rdata", {p0_rdata, p1_rdata}, 16'h0);
      check("const_as_linear", {hr_as, hr_linear}, 2'b00);

      // Both ports continuously valid: grants alternate starting with port 0
      for (int k = 0; k < 2; k++) begin
         e0[k] = model_byte(a0[k]);
         e1[k] = model_byte(a1[k]);
      end
      i0 = 0; i1 = 0; b = 0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, a0[0], 8'h0);
      drive(1, 1'b1, 1'b0, a1[0], 8'h0);
      #1;
      while ((q0.size() < 2 || q1.size() < 2) && b < 400) begin
         if (p0_rvalid) q0.push_back(p0_rdata);
         if (p1_rvalid) q1.push_back(p1_rdata);
         w = -1;
         if (p0_valid && p0_ready && p1_valid && p1_ready) w = 2;
         else if (p0_valid && p0_ready) w = 0;
         else if (p1_valid && p1_ready) w = 1;
         @(posedge clk); #1;
         if (w >= 0) gr.push_back(w);
         if (w == 0) begin
            mbuf_v = 1'b1; mbuf_w = int'(a0[i0] >> 1); exp_rd[0]++; i0++;
            if (i0 < 2) drive(0, 1'b1, 1'b0, a0[i0], 8'h0);
            else        drive(0, 1'b0, 1'b0, 24'h0, 8'h0);
         end else if (w == 1) begin
            mbuf_v = 1'b1; mbuf_w = int'(a1[i1] >> 1); exp_rd[1]++; i1++;
            if (i1 < 2) drive(1, 1'b1, 1'b0, a1[i1], 8'h0);
            else        drive(1, 1'b0, 1'b0, 24'h0, 8'h0);
         end
         @(negedge clk); #1;
         b++;
      end
      drive(0, 1'b0, 1'b0, 24'h0, 8'h0);
      drive(1, 1'b0, 1'b0, 24'h0, 8'h0);
      check("rr_grant_count", gr.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < gr.size()) check("rr_grant_order", gr[k], k % 2);
      for (int k = 0; k < 2; k++) begin
         if (k < q0.size()) check("rr_p0_data", q0[k], e0[k]);
         if (k < q1.size()) check("rr_p1_data", q1[k], e1[k]);
      end

      // Port 1 reads 0x2 (miss, 0x12) then 0x3 (buffer hit, 0x34)
      access(1, 1'b0, 24'h000002, 8'h00);
      access(1, 1'b0, 24'h000003, 8'h00);
      // Write 0xFF to buffered byte 0x2, then read it back as a hit
      access(0, 1'b1, 24'h000002, 8'hFF);
      access(1, 1'b0, 24'h000002, 8'h00);
      // Port 0 posted write of 0xA5 to odd byte 0x3
      access(0, 1'b1, 24'h000003, 8'hA5);

      // Slow ack: request held stable, no ready, rvalid one cycle after ack match
      ack_delay = 20;
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 24'h000040, 8'h00);
      #1;
      b = 0;
      while (!p1_ready && b < 200) begin @(negedge clk); #1; b++; end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 24'h0, 8'h0);
      drive(0, 1'b1, 1'b1, 24'h000050, 8'h5A);
      mbuf_v = 1'b1; mbuf_w = 24'h20; exp_rd[1]++;
      @(negedge clk);
      cap_a = hr_a; cap_d = hr_d; cap_ds = hr_ds; cap_we = hr_we;
      check("slow_hr_a", cap_a, TB_BASE + 32'h20);
      b = 0;
      while (hr_ack !== hr_req && b < 100) begin
         check("slow_hold", {hr_we, hr_a, hr_d, hr_ds, p0_ready, p1_ready},
               {cap_we, cap_a, cap_d, cap_ds, 2'b00});
         @(negedge clk); b++;
      end
      check("slow_ack_cycles", 64'(b >= 20 && b < 100), 64'd1);
      check("slow_no_rvalid_at_match", p1_rvalid, 1'b0);
      @(negedge clk);
      check("slow_rvalid_next", p1_rvalid, 1'b1);
      check("slow_rdata", p1_rdata, model_byte(24'h000040));
      ack_delay = 0;
      b = 0;
      while (!p0_ready && b < 200) begin @(negedge clk); #1; b++; end
      tog0 = n_tog;
      bmem[24'h50] = 8'h5A;
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 24'h0, 8'h0);
      @(negedge clk);
      check("held_write_toggle", 64'(n_tog - tog0), 64'd1);

      // Randomized traffic over a small window so buffer hits are frequent
      for (int n = 0; n < 40; n++) begin
         ack_delay = $urandom_range(0, 3);
         access($urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                24'($urandom_range(0, 15)), 8'($urandom));
      end
      ack_delay = 0;

      // Reset during WAIT drops the read; next read misses at hr_a = base
      ack_delay = 30;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 24'h000080, 8'h00);
      #1;
      b = 0;
      while (!p0_ready && b < 200) begin @(negedge clk); #1; b++; end
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 24'h0, 8'h0);
      repeat (5) @(negedge clk);
      check("in_wait_before_reset", hr_req != hr_ack, 1'b1);
      rv0 = n_rv[0];
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mbuf_v = 1'b0;
      ack_delay = 0;
      repeat (40) @(negedge clk);
      check("no_stale_rvalid", n_rv[0], rv0);
      check("req_after_reset", hr_req, 1'b0);
      access(0, 1'b0, 24'h000000, 8'h00);

      repeat (5) @(negedge clk);
      check("p0_rvalid_total", n_rv[0], exp_rd[0]);
      check("p1_rvalid_total", n_rv[1], exp_rd[1]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
